biriscv_fetch_queue: RTL
========================

// Module: biriscv_fetch_queue
// PURPOSE
//  Parametrised instruction queue between fetch and decode. Takes NUM_LANES-wide
//  fetch packets (pc, instrs, branch prediction, faults), drops lanes before the
//  entry offset or after a predicted-taken branch, and compacts the rest into a
//  DEPTH-entry circular buffer. Issues up to NUM_LANES in-order instrs per cycle,
//  so fetch bubbles and decode stalls are decoupled. Flushes on branch redirect.
// PARAMETERS
//  NUM_LANES   2   instrs per fetch packet / max issue per cycle (power of 2, >=1)
//  LANE_W      1   log2(NUM_LANES) (0 allowed when NUM_LANES=1)
//  DEPTH       8   queue entries, one instr each (power of 2, >= 2*NUM_LANES)
//  DEPTH_W     3   log2(DEPTH)
// PORTS
//  clk_i               in   1              clock
//  rst_i               in   1              async reset, active-high
//  flush_i             in   1              discard all entries and this cycle's push
//  fetch_valid_i       in   1              packet present
//  fetch_instr_i       in   32*NUM_LANES   lane j at [32j+31:32j]
//  fetch_pc_i          in   32             pc of first valid lane (word aligned)
//  fetch_pred_branch_i in   NUM_LANES      lane j predicted taken
//  fetch_fault_fetch_i in   1              bus error on packet
//  fetch_fault_page_i  in   1              page fault on packet
//  fetch_accept_o      out  1              packet taken when valid&accept
//  out_valid_o         out  NUM_LANES      issue lane k valid
//  out_instr_o         out  32*NUM_LANES   issue lane instrs
//  out_pc_o            out  32*NUM_LANES   issue lane pcs
//  out_fault_fetch_o   out  NUM_LANES      per-lane fetch fault
//  out_fault_page_o    out  NUM_LANES      per-lane page fault
//  out_accept_i        in   NUM_LANES      decode takes lane k
//  level_o             out  DEPTH_W+1      current occupancy
// BEHAVIOUR
//  - Reset (async, rst_i=1): rd/wr ptr=0, count=0 -> out_valid_o=0, level_o=0,
//    fetch_accept_o=1. Storage RAM not reset; outputs masked by count.
//  - fetch_accept_o = (DEPTH-count) >= NUM_LANES, from registered count only;
//    pops in the same cycle don't free space (no bypass).
//  - Lane mask: off=fetch_pc_i[LANE_W+1:2]; lane j kept iff j>=off and no
//    pred_branch in lanes off..j-1 (predicted lane kept, later lanes dropped).
//  - Fault packet (either fault bit): exactly one entry, pc=fetch_pc_i, its
//    fault flags set, instr field don't-care; pred bits ignored.
//  - Kept lanes written contiguously from wr_ptr in lane order; pc of lane j =
//    {fetch_pc_i[31:LANE_W+2], j[LANE_W-1:0], 2'b00}. Ptrs wrap mod DEPTH.
//  - Issue: lane k shows entry rd_ptr+k; out_valid_o[k] = count>k. Registered
//    storage: push visible at outputs next cycle (1-cycle latency, no fallthru).
//  - pop = count of leading ones of (out_valid_o & out_accept_i) from lane 0;
//    accept of lane k without lane k-1 accepted is ignored (in-order).
//  - count_next = count + pushed - popped; push and pop in same cycle legal.
//  - flush_i: highest priority; next cycle count=0, ptrs=0, out_valid_o=0, level_o=0;
//    push and pop of the flush cycle have no effect. fetch_accept_o unaffected in
//    flush cycle (push dropped silently).
//  - Fetch-side data held stable by producer while valid&!accept.
// STRUCTURE
//  - Shared include biriscv_fetch_defs.v: entry field widths/offsets
//    (instr 32, pc 32, fault_fetch, fault_page), lane-mask function.
//  - Sub-module biriscv_fetch_queue_compact: lane mask + fault -> per-lane
//    write offset and push count (pure combinational). Queue top holds RAM,
//    ptrs, count, issue muxes.
// TESTING (NUM_LANES=2, DEPTH=8 unless noted)
//  1 push pc=0x1000 {A,B}, pred=00 -> next cycle out_valid=11, A@0x1000,
//    B@0x1004; out_accept=11 -> level 2->0.
//  2 pc=0x1004 {X,B}; then pc=0x2000 pred=01 {C,D} -> entries B@0x1004,
//    C@0x2000 only, level=2.
//  3 4 full pushes w/o accept -> level 8, fetch_accept_o=0; out_accept=10 ->
//    no pop; 01 -> level 7, accept still 0; next 01 -> level 6, accept 1;
//    continue pushing/popping 20 packets -> order intact across ptr wrap.
//  4 pc=0x3000 fault_page=1 -> one entry, out_fault_page_o=01, pc 0x3000.
//  5 level 5, flush_i with push and pop in same cycle -> next cycle level 0,
//    out_valid=00, pushed instrs never issued.
//  6 rst_i asserted mid-cycle at level 6 -> outputs clear immediately
//    (before clock edge); NUM_LANES=4, DEPTH=16 rerun of 1-3.

Source files
------------

// File: rtl/biriscv_fetch_queue_pkg.sv
// Shared definitions for the fetch queue: entry layout, lane-keep rule and lane pc helper.
package biriscv_fetch_queue_pkg;

    localparam int FQ_INSTR_W   = 32;
    localparam int FQ_PC_W      = 32;
    localparam int FQ_MAX_LANES = 16;

    typedef struct packed {
        logic [FQ_INSTR_W-1:0] instr;
        logic [FQ_PC_W-1:0]    pc;
        logic                  fault_fetch;
        logic                  fault_page;
    } fq_entry_t;

    // A lane survives if it is at/after the entry offset and no earlier lane
    // from the offset onwards was predicted taken.
    function automatic logic fq_lane_keep(
        input logic [FQ_PC_W-1:0]      pc,
        input logic [FQ_MAX_LANES-1:0] pred,
        input int unsigned             lane,
        input int unsigned             num_lanes
    );
        int unsigned off;
        logic        keep;
        off  = (pc >> 2) & (num_lanes - 1);
        keep = (lane < num_lanes) && (lane >= off);
        for (int unsigned j = 0; j < FQ_MAX_LANES; j++) begin
            if ((j >= off) && (j < lane) && pred[j]) begin
                keep = 1'b0;
            end
        end
        return keep;
    endfunction

    function automatic logic [FQ_PC_W-1:0] fq_lane_pc(
        input logic [FQ_PC_W-1:0] pc,
        input int unsigned        lane,
        input int unsigned        num_lanes
    );
        return (pc & ~((num_lanes << 2) - 1)) | (lane << 2);
    endfunction

endpackage

// File: rtl/biriscv_fetch_queue_if.sv
// Fetch-side and issue-side handshake bundle of the fetch queue.
interface biriscv_fetch_queue_if #(
    parameter int NUM_LANES = 2
);
    logic                      fetch_valid;
    logic [32*NUM_LANES-1:0]   fetch_instr;
    logic [31:0]               fetch_pc;
    logic [NUM_LANES-1:0]      fetch_pred_branch;
    logic                      fetch_fault_fetch;
    logic                      fetch_fault_page;
    logic                      fetch_accept;

    logic [NUM_LANES-1:0]      out_valid;
    logic [32*NUM_LANES-1:0]   out_instr;
    logic [32*NUM_LANES-1:0]   out_pc;
    logic [NUM_LANES-1:0]      out_fault_fetch;
    logic [NUM_LANES-1:0]      out_fault_page;
    logic [NUM_LANES-1:0]      out_accept;

    modport master (
        output fetch_valid, fetch_instr, fetch_pc, fetch_pred_branch,
               fetch_fault_fetch, fetch_fault_page, out_accept,
        input  fetch_accept, out_valid, out_instr, out_pc,
               out_fault_fetch, out_fault_page
    );

    modport slave (
        input  fetch_valid, fetch_instr, fetch_pc, fetch_pred_branch,
               fetch_fault_fetch, fetch_fault_page, out_accept,
        output fetch_accept, out_valid, out_instr, out_pc,
               out_fault_fetch, out_fault_page
    );
endinterface

// File: rtl/biriscv_fetch_queue_compact.sv
// Lane selection for one fetch packet: which lanes are kept, where each lands
// relative to the write pointer, and how many entries are pushed.
module biriscv_fetch_queue_compact
    import biriscv_fetch_queue_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 1
) (
    input  logic [31:0]                    fetch_pc_i,
    input  logic [NUM_LANES-1:0]           pred_branch_i,
    input  logic                           fault_i,
    output logic [NUM_LANES-1:0]           keep_o,
    output logic [NUM_LANES-1:0][LANE_W:0] wr_off_o,
    output logic [LANE_W:0]                push_cnt_o
);

    logic [FQ_MAX_LANES-1:0] pred_wide;
    logic [NUM_LANES-1:0]    lane_keep;

    always_comb begin
        pred_wide                = '0;
        pred_wide[NUM_LANES-1:0] = pred_branch_i;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_keep
            assign lane_keep[gi] = fq_lane_keep(fetch_pc_i, pred_wide, gi, NUM_LANES);
        end
    endgenerate

    // A faulting packet collapses to a single entry carried in slot 0.
    assign keep_o = fault_i ? NUM_LANES'(1) : lane_keep;

    always_comb begin
        logic [LANE_W:0] run;
        run = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            wr_off_o[j] = run;
            run         = run + (LANE_W+1)'(keep_o[j]);
        end
        push_cnt_o = run;
    end

endmodule

// File: rtl/biriscv_fetch_queue.sv
// Instruction queue between fetch and decode: compacting push of fetch packets,
// circular storage, in-order multi-lane issue, flush on redirect.
module biriscv_fetch_queue
    import biriscv_fetch_queue_pkg::*;
#(
    parameter int NUM_LANES = 2,
    parameter int LANE_W    = 1,
    parameter int DEPTH     = 8,
    parameter int DEPTH_W   = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    biriscv_fetch_queue_if.slave bus,
    output logic [DEPTH_W:0]     level_o
);

    localparam int CNT_W = DEPTH_W + 1;

    logic [DEPTH_W-1:0]           rd_ptr_q, rd_ptr_d;
    logic [DEPTH_W-1:0]           wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]             count_q,  count_d;
    fq_entry_t                    mem_q [DEPTH];

    logic                         fetch_accept;
    logic                         fault_any;
    logic                         push_en;
    logic [NUM_LANES-1:0]         keep;
    logic [NUM_LANES-1:0][LANE_W:0] wr_off;
    logic [LANE_W:0]              push_cnt;
    logic [LANE_W:0]              pop_cnt;
    fq_entry_t                    lane_entry [NUM_LANES];
    logic [DEPTH_W-1:0]           wr_idx     [NUM_LANES];
    logic [NUM_LANES-1:0]         out_valid;

    // Space check uses registered occupancy only, so same-cycle pops never free room.
    assign fetch_accept     = (CNT_W'(DEPTH) - count_q) >= CNT_W'(NUM_LANES);
    assign bus.fetch_accept = fetch_accept;
    assign fault_any        = bus.fetch_fault_fetch | bus.fetch_fault_page;
    assign push_en          = bus.fetch_valid & fetch_accept & ~flush_i;

    biriscv_fetch_queue_compact #(
        .NUM_LANES (NUM_LANES),
        .LANE_W    (LANE_W)
    ) u_compact (
        .fetch_pc_i    (bus.fetch_pc),
        .pred_branch_i (bus.fetch_pred_branch),
        .fault_i       (fault_any),
        .keep_o        (keep),
        .wr_off_o      (wr_off),
        .push_cnt_o    (push_cnt)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            logic [DEPTH_W-1:0] rd_idx;
            fq_entry_t          rd_entry;

            assign lane_entry[gi] = '{
                instr:       bus.fetch_instr[32*gi +: 32],
                pc:          fault_any ? bus.fetch_pc : fq_lane_pc(bus.fetch_pc, gi, NUM_LANES),
                fault_fetch: bus.fetch_fault_fetch,
                fault_page:  bus.fetch_fault_page
            };
            assign wr_idx[gi] = wr_ptr_q + DEPTH_W'(wr_off[gi]);

            assign rd_idx                    = rd_ptr_q + DEPTH_W'(gi);
            assign rd_entry                  = mem_q[rd_idx];
            assign out_valid[gi]             = count_q > CNT_W'(gi);
            assign bus.out_instr[32*gi +: 32] = rd_entry.instr;
            assign bus.out_pc[32*gi +: 32]    = rd_entry.pc;
            assign bus.out_fault_fetch[gi]   = rd_entry.fault_fetch;
            assign bus.out_fault_page[gi]    = rd_entry.fault_page;
        end
    endgenerate

    assign bus.out_valid = out_valid;
    assign level_o       = count_q;

    // Pops stop at the first lane that is not both valid and accepted.
    always_comb begin
        logic run;
        run     = 1'b1;
        pop_cnt = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            run     = run & out_valid[k] & bus.out_accept[k];
            pop_cnt = pop_cnt + (LANE_W+1)'(run);
        end
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q + DEPTH_W'(pop_cnt);
        wr_ptr_d = wr_ptr_q + (push_en ? DEPTH_W'(push_cnt) : '0);
        count_d  = count_q + (push_en ? CNT_W'(push_cnt) : '0) - CNT_W'(pop_cnt);
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale entries are hidden by the occupancy mask.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NUM_LANES; j++) begin
            if (push_en && keep[j]) begin
                mem_q[wr_idx[j]] <= lane_entry[j];
            end
        end
    end

endmodule
